// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// io_pkg : shared constants and sequencer states for the UART output path
// Rev 1.0
// ============================================================================
package io_pkg;

    localparam int MEM_OUTPUT_SIZE     = 1024;
    localparam int LOG_MEM_OUTPUT_SIZE = 10;
    localparam int CLKS_PER_BIT        = 868;
    localparam int UART_FRAME_BITS     = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/output_sender_transmitter.sv
`default_nettype none
// ============================================================================
// transmitter : UART 8N1 byte serialiser, LSB first, one-cycle tx_done
// Rev 1.0
// ============================================================================
module transmitter #(
    parameter int CLKS_PER_BIT = io_pkg::CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       UART_TX,
    output logic       tx_done
);
    import io_pkg::*;

    localparam int              c_cnt_w      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    logic               r_active;
    logic [3:0]         r_bits_left;
    logic [8:0]         r_shift;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tx;
    logic               r_done;

    // r_shift holds the bits still to go (data then stop); start bit is driven on launch
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_active    <= 1'b0;
            r_bits_left <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (tx_start) begin
                    r_active    <= 1'b1;
                    r_tx        <= 1'b0;
                    r_shift     <= {1'b1, tx_data};
                    r_bits_left <= 4'(UART_FRAME_BITS - 1);
                    r_cnt       <= c_cnt_reload;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_bits_left == 4'd0 && r_cnt == c_cnt_one) begin
                    r_done <= 1'b1;
                end
            end else if (r_bits_left == 4'd0) begin
                r_active <= 1'b0;
            end else begin
                r_tx        <= r_shift[0];
                r_shift     <= {1'b0, r_shift[8:1]};
                r_bits_left <= r_bits_left - 4'd1;
                r_cnt       <= c_cnt_reload;
            end
        end
    end

    assign UART_TX = r_tx;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: rtl/output_sender.sv
`default_nettype none
// ============================================================================
// output_sender : word FIFO feeding a UART, each word sent as 4 bytes MSB first
// Rev 1.0
// ============================================================================
module output_sender #(
    parameter int MEM_OUTPUT_SIZE     = io_pkg::MEM_OUTPUT_SIZE,
    parameter int LOG_MEM_OUTPUT_SIZE = io_pkg::LOG_MEM_OUTPUT_SIZE,
    parameter int CLKS_PER_BIT        = io_pkg::CLKS_PER_BIT
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         push_valid,
    input  logic [31:0]                  push_data,
    output logic                         push_ready,
    output logic [LOG_MEM_OUTPUT_SIZE:0] queue_count,
    output logic                         busy,
    output logic                         UART_TX
);
    import io_pkg::*;

    localparam int c_log = LOG_MEM_OUTPUT_SIZE;

    logic [31:0]  r_mem [0:MEM_OUTPUT_SIZE-1];
    logic [c_log:0] r_head;
    logic [c_log:0] r_tail;
    seq_state_t   r_state;
    logic [31:0]  r_shift;
    logic [1:0]   r_byte_idx;
    logic         r_tx_start;
    logic [7:0]   r_tx_data;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_tx_done;

    // Full: pointers differ only in the wrap bit
    assign w_empty = (r_head == r_tail);
    assign w_full  = ((r_head ^ r_tail) == {1'b1, {c_log{1'b0}}});
    assign w_push  = push_valid && !w_full;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_tail[c_log-1:0]] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tail <= '0;
        end else if (w_push) begin
            r_tail <= r_tail + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_head     <= '0;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_shift    <= r_mem[r_head[c_log-1:0]];
                        r_head     <= r_head + 1'b1;
                        r_byte_idx <= 2'd0;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= r_shift[31:24];
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (w_tx_done) begin
                        r_shift    <= {r_shift[23:0], 8'h00};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_state    <= (r_byte_idx == 2'd3) ? IDLE : SEND;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    transmitter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_transmitter (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .tx_data (r_tx_data),
        .tx_start(r_tx_start),
        .UART_TX (UART_TX),
        .tx_done (w_tx_done)
    );

    assign push_ready  = !w_full;
    assign queue_count = r_tail - r_head;
    assign busy        = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire
